fc_layer_gen: RTL

Parametrised fully-connected output stage for the 1D-CNN ECG classifier. It sits after the last conv/pool layer and replaces the fixed-size FC layer. It loads biases and weights over the same packed stb/ack stream it later uses for activations, then computes all OUT_CH dot products in parallel. It returns biased, optionally ReLU'd logits together with the argmax class index.

---
 rtl/fc_layer_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fc_layer_gen.sv
// Fully-connected output stage: loads biases and weights over the packed
// stb/ack beat stream, accumulates OUT_CH dot products in parallel, then
// presents biased (optionally ReLU'd) logits and the argmax class index.
module fc_layer_gen #(
  parameter int DW     = 32,
  parameter int FRAC   = 0,
  parameter int IN_CH  = 16,
  parameter int IN_SEQ = 1,
  parameter int OUT_CH = 5,
  parameter int RELU   = 0,
  parameter int CW     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 i_EN_w,
  input  logic                 i_EN_c,
  output logic                 o_busy,
  input  logic [DW*IN_CH-1:0]  i_data,
  input  logic                 i_stb_in,
  output logic                 o_ack_in,
  output logic [DW*OUT_CH-1:0] o_data,
  output logic [CW-1:0]        o_class,
  output logic                 o_stb_out,
  input  logic                 i_ack_out
);

  localparam int NB = (OUT_CH + IN_CH - 1) / IN_CH;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int OW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int SW = (IN_SEQ > 1) ? $clog2(IN_SEQ) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_BIAS = 3'd1;
  localparam logic [2:0] LD_WGT  = 3'd2;
  localparam logic [2:0] ACC     = 3'd3;
  localparam logic [2:0] OUT     = 3'd4;

  logic [2:0]          state;
  logic [BW-1:0]       bcnt;
  logic [OW-1:0]       row_cnt;
  logic [SW-1:0]       seg;
  logic                stb_out;
  logic [DW-1:0]       bias [OUT_CH];
  logic [DW*IN_CH-1:0] wgt  [OUT_CH][IN_SEQ];
  logic [DW-1:0]       acc  [OUT_CH];
  logic [DW-1:0]       delta [OUT_CH];
  logic [DW-1:0]       y [OUT_CH];
  logic [DW-1:0]       best_val;
  logic [CW-1:0]       best_idx;

  logic hs, last_b, last_row, last_seg;

  assign o_busy    = (state != IDLE);
  assign o_ack_in  = (state == LD_BIAS) || (state == LD_WGT) || (state == ACC);
  assign o_stb_out = stb_out;
  assign o_class   = best_idx;
  assign hs        = i_stb_in & o_ack_in;
  assign last_b    = (bcnt == BW'(NB - 1));
  assign last_row  = (row_cnt == OW'(OUT_CH - 1));
  assign last_seg  = (seg == SW'(IN_SEQ - 1));

  // Phase sequencing, beat counters and the registered result strobe.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      bcnt    <= '0;
      row_cnt <= '0;
      seg     <= '0;
      stb_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_EN_w) begin
            state   <= LD_BIAS;
            bcnt    <= '0;
            row_cnt <= '0;
            seg     <= '0;
          end else if (i_EN_c) begin
            state <= ACC;
            seg   <= '0;
          end
        end
        LD_BIAS: begin
          if (hs) begin
            if (last_b) begin
              state <= LD_WGT;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        LD_WGT: begin
          if (hs) begin
            if (last_seg) begin
              seg <= '0;
              if (last_row) begin
                row_cnt <= '0;
                state   <= IDLE;
              end else begin
                row_cnt <= row_cnt + OW'(1);
              end
            end else begin
              seg <= seg + SW'(1);
            end
          end
        end
        ACC: begin
          if (hs) begin
            if (last_seg) begin
              seg     <= '0;
              state   <= OUT;
              stb_out <= 1'b1;
            end else begin
              seg <= seg + SW'(1);
            end
          end
        end
        OUT: begin
          if (i_ack_out) begin
            state   <= IDLE;
            stb_out <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          stb_out <= 1'b0;
        end
      endcase
    end
  end

  // Bias capture: beat b carries bias[b*IN_CH +: IN_CH]; words past OUT_CH drop.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int o = 0; o < OUT_CH; o++) bias[o] <= '0;
    end else if ((state == LD_BIAS) && hs) begin
      for (int o = 0; o < OUT_CH; o++) begin
        if (bcnt == BW'(o / IN_CH)) bias[o] <= i_data[(o % IN_CH)*DW +: DW];
      end
    end
  end

  // Weight capture: one beat per (row, segment), rows outer, segments inner.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int o = 0; o < OUT_CH; o++)
        for (int s = 0; s < IN_SEQ; s++) wgt[o][s] <= '0;
    end else if ((state == LD_WGT) && hs) begin
      for (int o = 0; o < OUT_CH; o++)
        for (int s = 0; s < IN_SEQ; s++)
          if ((row_cnt == OW'(o)) && (seg == SW'(s))) wgt[o][s] <= i_data;
    end
  end

  // Per-neuron partial dot product of the current beat with its weight segment.
  always_comb begin
    logic [DW*IN_CH-1:0] row;
    logic [2*DW-1:0]     xe, we, prod;
    logic [DW-1:0]       sum;
    row  = '0;
    xe   = '0;
    we   = '0;
    prod = '0;
    sum  = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      row = '0;
      for (int s = 0; s < IN_SEQ; s++) begin
        if (seg == SW'(s)) row = wgt[o][s];
        else               row = row;
      end
      sum = '0;
      for (int k = 0; k < IN_CH; k++) begin
        // Low 2*DW bits of the sign-extended product equal the signed product;
        // taking bits [FRAC +: DW] is the arithmetic shift followed by truncation.
        xe   = {{DW{i_data[k*DW+DW-1]}}, i_data[k*DW +: DW]};
        we   = {{DW{row[k*DW+DW-1]}}, row[k*DW +: DW]};
        prod = xe * we;
        sum  = sum + prod[FRAC +: DW];
      end
      delta[o] = sum;
    end
  end

  // Accumulators: cleared when an inference starts, updated on every ACC beat.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int o = 0; o < OUT_CH; o++) acc[o] <= '0;
    end else if ((state == IDLE) && !i_EN_w && i_EN_c) begin
      for (int o = 0; o < OUT_CH; o++) acc[o] <= '0;
    end else if ((state == ACC) && hs) begin
      for (int o = 0; o < OUT_CH; o++) acc[o] <= acc[o] + delta[o];
    end
  end

  // Logits (bias + acc, optional ReLU) and lowest-index argmax.
  always_comb begin
    o_data   = '0;
    best_val = '0;
    best_idx = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      y[o] = acc[o] + bias[o];
      if ((RELU != 0) && y[o][DW-1]) y[o] = '0;
      else                           y[o] = y[o];
    end
    best_val = y[0];
    for (int o = 1; o < OUT_CH; o++) begin
      if ($signed(y[o]) > $signed(best_val)) begin
        best_val = y[o];
        best_idx = CW'(o);
      end else begin
        best_val = best_val;
      end
    end
    for (int o = 0; o < OUT_CH; o++) o_data[o*DW +: DW] = y[o];
  end

endmodule
